// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and helpers for the TMR voter and its per-lane health trackers.
package cv32e40p_tmr_pkg;

  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {
    LANE_HEALTHY = 2'd0,
    LANE_SUSPECT = 2'd1,
    LANE_FAILED  = 2'd2
  } lane_state_e;

  typedef enum logic [1:0] {
    MODE_TMR   = 2'd0,
    MODE_DMR   = 2'd1,
    MODE_FATAL = 2'd2
  } vote_mode_e;

  function automatic logic [1:0] popcount3(input logic [NUM_LANES-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_lane_health.sv
// Per-lane health FSM: counts consecutive mismatching valid samples and latches FAILED
// once ERR_THRESH is reached; only clear_i or reset bring the lane back.
module cv32e40p_tmr_lane_health
  import cv32e40p_tmr_pkg::*;
#(
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic valid_i,
  input  logic mismatch_i,
  output logic failed_o
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);

  lane_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc  = cnt_q + 1'b1;
  assign failed_o = (state_q == LANE_FAILED);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LANE_HEALTHY;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= LANE_HEALTHY;
      cnt_q   <= '0;
    end else if (valid_i) begin
      case (state_q)
        LANE_HEALTHY: begin
          if (mismatch_i) begin
            cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
            state_q <= (ERR_THRESH <= 1) ? LANE_FAILED : LANE_SUSPECT;
          end
        end
        LANE_SUSPECT: begin
          if (mismatch_i) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= THRESH) state_q <= LANE_FAILED;
          end else begin
            cnt_q   <= '0;
            state_q <= LANE_HEALTHY;
          end
        end
        LANE_FAILED: state_q <= LANE_FAILED;
        default: begin
          state_q <= LANE_HEALTHY;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_tmr_voter.sv
// Registered TMR voter (1-cycle latency) that degrades to duplex compare, then fatal,
// as lanes are judged failed by their health trackers.
module cv32e40p_tmr_voter
  import cv32e40p_tmr_pkg::*;
#(
  parameter int WIDTH      = 33,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] lane0_i,
  input  logic [WIDTH-1:0] lane1_i,
  input  logic [WIDTH-1:0] lane2_i,
  output logic [WIDTH-1:0] voted_o,
  output logic             voted_valid_o,
  output logic [2:0]       mismatch_o,
  output logic             uncorrectable_o,
  output logic [2:0]       lane_failed_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] vote_val;
  logic [2:0]       vote_mm;
  logic             vote_unc;
  logic             dmr_diff;
  logic [1:0]       nfail;
  vote_mode_e       mode;

  assign maj   = (lane0_i & lane1_i) | (lane0_i & lane2_i) | (lane1_i & lane2_i);
  assign nfail = popcount3(lane_failed_o);

  always_comb begin
    mode = MODE_FATAL;
    if (nfail == 2'd0)      mode = MODE_TMR;
    else if (nfail == 2'd1) mode = MODE_DMR;
  end

  always_comb begin
    vote_val = maj;
    vote_mm  = '0;
    vote_unc = 1'b0;
    dmr_diff = 1'b0;
    case (mode)
      MODE_TMR: begin
        vote_mm  = {lane2_i != maj, lane1_i != maj, lane0_i != maj};
        vote_unc = (popcount3(vote_mm) >= 2'd2);
      end
      MODE_DMR: begin
        // Both survivors are flagged on disagreement: with two votes we cannot tell who is wrong.
        case (lane_failed_o)
          3'b001: begin
            vote_val = lane1_i;
            dmr_diff = (lane1_i != lane2_i);
            vote_mm  = {dmr_diff, dmr_diff, 1'b0};
          end
          3'b010: begin
            vote_val = lane0_i;
            dmr_diff = (lane0_i != lane2_i);
            vote_mm  = {dmr_diff, 1'b0, dmr_diff};
          end
          default: begin
            vote_val = lane0_i;
            dmr_diff = (lane0_i != lane1_i);
            vote_mm  = {1'b0, dmr_diff, dmr_diff};
          end
        endcase
        vote_unc = dmr_diff;
      end
      default: begin
        if (!lane_failed_o[0])      vote_val = lane0_i;
        else if (!lane_failed_o[1]) vote_val = lane1_i;
        else if (!lane_failed_o[2]) vote_val = lane2_i;
        else                        vote_val = lane0_i;
        vote_unc = 1'b1;
      end
    endcase
  end

  cv32e40p_tmr_lane_health #(.ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)) u_health0 (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
    .mismatch_i(vote_mm[0]), .failed_o(lane_failed_o[0])
  );
  cv32e40p_tmr_lane_health #(.ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)) u_health1 (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
    .mismatch_i(vote_mm[1]), .failed_o(lane_failed_o[1])
  );
  cv32e40p_tmr_lane_health #(.ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)) u_health2 (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
    .mismatch_i(vote_mm[2]), .failed_o(lane_failed_o[2])
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      voted_o         <= '0;
      voted_valid_o   <= 1'b0;
      mismatch_o      <= '0;
      uncorrectable_o <= 1'b0;
    end else begin
      voted_valid_o <= valid_i;
      if (valid_i) begin
        voted_o         <= vote_val;
        mismatch_o      <= vote_mm;
        uncorrectable_o <= vote_unc;
      end else begin
        mismatch_o      <= '0;
        uncorrectable_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
      fatal_o   <= 1'b0;
    end else if (clear_i) begin
      err_cnt_o <= '0;
      fatal_o   <= 1'b0;
    end else begin
      if (valid_i && (|vote_mm) && (err_cnt_o != {CNT_W{1'b1}}))
        err_cnt_o <= err_cnt_o + 1'b1;
      if (nfail >= 2'd2) fatal_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_tmr_voter.sv
// Randomised and directed bench for cv32e40p_tmr_voter against a behavioural model.
module tb_cv32e40p_tmr_voter;

  localparam int WIDTH      = 33;
  localparam int ERR_THRESH = 4;
  localparam int CNT_W      = 8;
  localparam int ERR_MAX    = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             clear_i;
  logic             valid_i;
  logic [WIDTH-1:0] lane0_i, lane1_i, lane2_i;
  logic [WIDTH-1:0] voted_o;
  logic             voted_valid_o;
  logic [2:0]       mismatch_o;
  logic             uncorrectable_o;
  logic [2:0]       lane_failed_o;
  logic             fatal_o;
  logic [CNT_W-1:0] err_cnt_o;

  cv32e40p_tmr_voter #(.WIDTH(WIDTH), .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
    .lane0_i(lane0_i), .lane1_i(lane1_i), .lane2_i(lane2_i),
    .voted_o(voted_o), .voted_valid_o(voted_valid_o), .mismatch_o(mismatch_o),
    .uncorrectable_o(uncorrectable_o), .lane_failed_o(lane_failed_o),
    .fatal_o(fatal_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit               m_failed [3];
  int               m_consec [3];
  int               m_err;
  bit               m_fatal;
  logic [WIDTH-1:0] m_voted;
  bit               m_vv;
  logic [2:0]       m_mm;
  bit               m_unc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_failed[k] = 1'b0;
      m_consec[k] = 0;
    end
    m_err = 0; m_fatal = 1'b0; m_voted = '0; m_vv = 1'b0; m_mm = '0; m_unc = 1'b0;
  endtask

  task automatic check_all(input string ph);
    check_eq({ph, ".voted"},  64'(voted_o),         64'(m_voted));
    check_eq({ph, ".vvalid"}, 64'(voted_valid_o),   64'(m_vv));
    check_eq({ph, ".mism"},   64'(mismatch_o),      64'(m_mm));
    check_eq({ph, ".uncorr"}, 64'(uncorrectable_o), 64'(m_unc));
    check_eq({ph, ".failed"}, 64'(lane_failed_o),   64'({m_failed[2], m_failed[1], m_failed[0]}));
    check_eq({ph, ".fatal"},  64'(fatal_o),         64'(m_fatal));
    check_eq({ph, ".errcnt"}, 64'(err_cnt_o),       64'(m_err));
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rnd_mask();
    logic [WIDTH-1:0] m;
    m = rnd();
    if (m == '0) m = 1;
    return m;
  endfunction

  // One clock: drive inputs, predict from the specification's rules, check after the edge.
  task automatic step(input string ph, input bit v, input bit c,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] ln [3];
    logic [WIDTH-1:0] val;
    logic [2:0]       mm;
    bit               unc;
    int               nf, first, second, cnt, nmm;
    ln[0] = a; ln[1] = b; ln[2] = d;
    valid_i = v; clear_i = c; lane0_i = a; lane1_i = b; lane2_i = d;
    nf = 0;
    for (int k = 0; k < 3; k++) if (m_failed[k]) nf++;
    mm = '0; unc = 1'b0; val = '0;
    if (nf == 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt = int'(ln[0][i]) + int'(ln[1][i]) + int'(ln[2][i]);
        val[i] = (cnt >= 2);
      end
      nmm = 0;
      for (int k = 0; k < 3; k++) begin
        mm[k] = (ln[k] != val);
        if (mm[k]) nmm++;
      end
      unc = (nmm >= 2);
    end else if (nf == 1) begin
      first = -1; second = -1;
      for (int k = 0; k < 3; k++)
        if (!m_failed[k]) begin
          if (first < 0) first = k; else second = k;
        end
      val = ln[first];
      if (ln[first] != ln[second]) begin
        mm[first] = 1'b1; mm[second] = 1'b1; unc = 1'b1;
      end
    end else begin
      val = ln[0];
      for (int k = 2; k >= 0; k--) if (!m_failed[k]) val = ln[k];
      unc = 1'b1;
    end
    m_vv = v;
    if (v) begin
      m_voted = val; m_mm = mm; m_unc = unc;
    end else begin
      m_mm = '0; m_unc = 1'b0;
    end
    if (c) begin
      for (int k = 0; k < 3; k++) begin
        m_failed[k] = 1'b0; m_consec[k] = 0;
      end
      m_err = 0; m_fatal = 1'b0;
    end else begin
      if (v) begin
        for (int k = 0; k < 3; k++)
          if (!m_failed[k]) begin
            if (mm[k]) begin
              m_consec[k]++;
              if (m_consec[k] >= ERR_THRESH) m_failed[k] = 1'b1;
            end else m_consec[k] = 0;
          end
        if (mm != 0 && m_err < ERR_MAX) m_err++;
      end
      if (nf >= 2) m_fatal = 1'b1;
    end
    @(posedge clk_i);
    #1;
    check_all(ph);
  endtask

  logic [WIDTH-1:0] x, y;
  logic [WIDTH-1:0] k_val;

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0;
    lane0_i = '0; lane1_i = '0; lane2_i = '0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk_i); #1; rst_i = 1'b0;

    // all lanes equal
    k_val = 33'h1_2345_6789;
    step("equal", 1, 0, k_val, k_val, k_val);
    check_eq("equal.const", 64'(voted_o), 64'h1_2345_6789);

    // single transient flip on lane1
    step("flip1", 1, 0, k_val, k_val ^ 33'd1, k_val);
    check_eq("flip1.mm_const", 64'(mismatch_o), 64'b010);
    step("flip1.ok", 1, 0, k_val, k_val, k_val);
    step("idle", 0, 0, rnd(), rnd(), rnd());

    // lane2 fails, then duplex disagreement
    for (int i = 0; i < 4; i++) begin
      x = rnd();
      step("l2bad", 1, 0, x, x, x ^ rnd_mask());
    end
    check_eq("l2bad.failed_const", 64'(lane_failed_o), 64'b100);
    x = rnd(); y = x ^ rnd_mask();
    step("dmr", 1, 0, x, y, rnd());
    check_eq("dmr.mm_const", 64'(mismatch_o), 64'b011);
    check_eq("dmr.voted_lane0", 64'(voted_o), 64'(x));
    step("clr1", 0, 1, '0, '0, '0);

    // lanes 0 and 2 fail together
    for (int i = 0; i < 4; i++) begin
      x = rnd();
      step("l02bad", 1, 0, x ^ (33'd1 << i), x, x ^ (33'd1 << (i + 8)));
    end
    check_eq("l02bad.failed_const", 64'(lane_failed_o), 64'b101);
    for (int i = 0; i < 3; i++) begin
      x = rnd();
      step("fatal", 1, 0, rnd(), x, rnd());
      check_eq("fatal.voted_lane1", 64'(voted_o), 64'(x));
    end
    check_eq("fatal.sticky_const", 64'(fatal_o), 64'd1);
    step("clr2", 0, 1, '0, '0, '0);

    // rotating single-lane corruption saturates the error counter
    for (int i = 0; i < 300; i++) begin
      x = rnd();
      step("sat", 1, 0, (i % 3 == 0) ? x ^ rnd_mask() : x,
                        (i % 3 == 1) ? x ^ rnd_mask() : x,
                        (i % 3 == 2) ? x ^ rnd_mask() : x);
    end
    check_eq("sat.errcnt_const", 64'(err_cnt_o), 64'(ERR_MAX));
    x = rnd();
    step("clrv", 1, 1, x, x, x ^ rnd_mask());
    check_eq("clrv.errcnt_const", 64'(err_cnt_o), 64'd0);

    // async reset in the middle of a suspect run
    for (int i = 0; i < 3; i++) begin
      x = rnd();
      step("susp", 1, 0, x ^ rnd_mask(), x, x);
    end
    #2; rst_i = 1'b1; #1;
    model_reset();
    check_all("arst");
    @(posedge clk_i); #1; rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = rnd();
      step("post", 1, 0, x ^ rnd_mask(), x, x);
    end
    check_eq("post.failed_const", 64'(lane_failed_o), 64'b000);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      x = rnd();
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
           ($urandom_range(0, 4) == 0) ? x ^ rnd_mask() : x,
           ($urandom_range(0, 4) == 0) ? x ^ rnd_mask() : x,
           ($urandom_range(0, 4) == 0) ? x ^ rnd_mask() : x);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_voter.md
Name: cv32e40p_tmr_voter

Overview:
- Parametrised triple-modular-redundancy voter and lane-health tracker for replicated datapath results, e.g. the three 33-bit divider copies exported at core top.
- Produces a registered bitwise-majority result and flags per-lane disagreement.
- Tracks each lane's health with a small FSM. Once a lane is judged failed, it is excluded and the block degrades to duplex compare mode.
- Sits between the replicated units and their consumer, and feeds error status to the core's error/status outputs.

Parameters:
- WIDTH, 33, bit width of each lane's result.
- ERR_THRESH, 4, consecutive mismatching valid samples before a lane is declared failed; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the saturating mismatch-event counter and the per-lane consecutive counters.

Ports:
- clk_i, in, 1, core clock.
- rst_i, in, 1, asynchronous active-high reset.
- clear_i, in, 1, synchronous clear of health state, counters and fatal flag.
- valid_i, in, 1, the three lanes carry a sample this cycle.
- lane0_i, in, WIDTH, lane 0 result.
- lane1_i, in, WIDTH, lane 1 result.
- lane2_i, in, WIDTH, lane 2 result.
- voted_o, out, WIDTH, voted result (registered).
- voted_valid_o, out, 1, voted_o valid; one-cycle pulse.
- mismatch_o, out, 3, per-lane disagreement with the voted value, aligned to voted_valid_o.
- uncorrectable_o, out, 1, no trustworthy result for this sample, aligned to voted_valid_o.
- lane_failed_o, out, 3, sticky per-lane FAILED indication.
- fatal_o, out, 1, sticky; two or more lanes have failed.
- err_cnt_o, out, CNT_W, saturating count of valid samples with any mismatch.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - All outputs and state clear to 0; voted_o=0.
  - All lanes HEALTHY; consecutive counters 0.
- Latency is fixed at 1 cycle. A sample accepted with valid_i in cycle N appears on voted_o, voted_valid_o, mismatch_o and uncorrectable_o in cycle N+1.
- valid_i=0: voted_valid_o=0 next cycle. voted_o holds its last value. mismatch_o and uncorrectable_o go to 0. No health or counter update.
- TMR mode (no lane FAILED):
  - voted = bitwise majority (l0&l1 | l0&l2 | l1&l2).
  - mismatch[k] = (lane k != voted).
  - uncorrectable = 1 when two or more mismatch bits are set.
- Duplex mode (exactly one lane FAILED):
  - voted = the lower-index non-failed lane.
  - If the two non-failed lanes differ, uncorrectable=1 and mismatch is set for both of them.
  - The failed lane's mismatch bit is forced to 0.
- Fatal mode (two or more lanes FAILED):
  - voted = the lowest-index non-failed lane, or lane0 if all three have failed.
  - uncorrectable=1 on every valid sample.
  - mismatch_o=0.
- Per-lane health FSM, advanced only on valid_i=1:
  - HEALTHY: mismatch → SUSPECT, cnt=1. If ERR_THRESH=1, go directly to FAILED.
  - SUSPECT: mismatch → cnt+1, and if cnt+1 ≥ ERR_THRESH → FAILED. Match → HEALTHY, cnt=0.
  - FAILED: absorbing state; left only via clear_i or reset.
- Simultaneous failures:
  - If two lanes reach FAILED in the same cycle, both are marked.
  - fatal_o asserts on the cycle after the count of FAILED lanes becomes ≥2, and stays sticky.
- err_cnt_o increments on each valid sample with any mismatch bit set, and saturates at 2^CNT_W-1 (no wrap).
- clear_i=1:
  - Next cycle, all lanes are HEALTHY, counters are 0, err_cnt_o=0, fatal_o=0.
  - clear_i takes priority over health and counter updates in the same cycle.
  - A simultaneous valid_i sample is still voted and output, using the pre-clear mode, but does not update health or counters.
- Mode selection uses the registered health state. A lane failing in cycle N affects votes of samples accepted from cycle N+1 onward.

Decomposition:
- Shared package cv32e40p_tmr_pkg holds:
  - lane_state_e {LANE_HEALTHY, LANE_SUSPECT, LANE_FAILED};
  - vote_mode_e {MODE_TMR, MODE_DMR, MODE_FATAL};
  - constant NUM_LANES=3.
- Sub-module cv32e40p_tmr_lane_health: one per-lane FSM plus consecutive counter, instantiated three times.
- Voting, mode selection, output register and err_cnt stay in the top block.

Test Plan:
- All lanes equal, valid_i=1 with value 0x1_2345_6789 → next cycle voted_o=0x1_2345_6789, voted_valid_o=1, mismatch_o=000, err_cnt_o unchanged.
- Lane1 bit 0 flipped once, then matching → voted_o correct, mismatch_o=010, err_cnt_o=1, lane1 returns to HEALTHY, lane_failed_o=000.
- Lane2 corrupted for 4 consecutive valid samples (ERR_THRESH=4) → lane_failed_o=100 after the 4th. A subsequent lane0≠lane1 sample → voted_o=lane0, uncorrectable_o=1, mismatch_o=011.
- Lanes 0 and 2 corrupted in the same cycles for 4 samples → lane_failed_o=101, fatal_o=1 sticky, later valid samples give voted_o=lane1 and uncorrectable_o=1.
- Mismatch every valid sample for 300 samples with CNT_W=8 → err_cnt_o saturates at 255. Then clear_i=1 with valid_i=1 → sample output, next cycle err_cnt_o=0, lane_failed_o=000, fatal_o=0.
- Assert rst_i mid-SUSPECT (lane0 cnt=3) → outputs 0 immediately. After release, 3 lane0 mismatches do not set lane_failed_o[0].
